// File: rtl/apb_req_pkg.sv
// Shared types and constants for the APB transaction requester.
package apb_req_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StResp
  } apb_req_state_e;

  localparam int unsigned DefaultTimeout = 1024;

endpackage

// File: rtl/apb_txn_requester_if.sv
// APB bus bundle between the requester (master) and a completer (slave).
interface apb_txn_requester_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  psel;
  logic                  penable;
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  pwrite;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, paddr, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, paddr, pwrite, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clear has priority over increment.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);
  logic [WIDTH-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
endmodule

// File: rtl/apb_txn_requester.sv
// Turns one command into one APB transfer and reports data, error, timeout and latency.
// Defining APB_REQ_STATS_EN adds transaction/error/timeout counters and a max-latency tracker.
module apb_txn_requester
  import apb_req_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned LAT_WIDTH      = 16,
  parameter int unsigned TIMEOUT_CYCLES = DefaultTimeout
) (
  input  logic                  pclk,
  input  logic                  preset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  cmd_write,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic [LAT_WIDTH-1:0]  rsp_latency,
`ifdef APB_REQ_STATS_EN
  input  logic                  stat_clear,
  output logic [31:0]           stat_txn_count,
  output logic [31:0]           stat_timeout_count,
  output logic [31:0]           stat_err_count,
  output logic [LAT_WIDTH-1:0]  stat_max_latency,
`endif
  apb_txn_requester_if.master   apb
);
  localparam int unsigned WaitWidth = $clog2(TIMEOUT_CYCLES);

  apb_req_state_e state_d, state_q;

  logic [ADDR_WIDTH-1:0] paddr_q;
  logic                  pwrite_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_err_q;
  logic                  rsp_timeout_q;
  logic [LAT_WIDTH-1:0]  rsp_latency_q;
  logic [LAT_WIDTH-1:0]  lat_cnt;
  logic [WaitWidth-1:0]  wait_cnt;
  logic                  accept;
  logic                  timeout_hit;

  assign accept      = cmd_valid && cmd_ready;
  assign timeout_hit = (state_q == StAccess) && !apb.pready &&
                       (wait_cnt == WaitWidth'(TIMEOUT_CYCLES - 1));

  // Reads 1 in SETUP and SETUP+k during the k-th ACCESS cycle, i.e. cycles with psel high.
  sat_counter #(.WIDTH(LAT_WIDTH)) u_lat_cnt (
    .clk_i   (pclk),
    .rst_ni  (preset_n),
    .clear_i (state_q == StResp),
    .inc_i   (accept || (state_q == StSetup) || (state_q == StAccess)),
    .count_o (lat_cnt)
  );

  // Reads k-1 during the k-th ACCESS cycle.
  sat_counter #(.WIDTH(WaitWidth)) u_wait_cnt (
    .clk_i   (pclk),
    .rst_ni  (preset_n),
    .clear_i (state_q != StAccess),
    .inc_i   (state_q == StAccess),
    .count_o (wait_cnt)
  );

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = StSetup;
      StSetup:  state_d = StAccess;
      StAccess: if (apb.pready || timeout_hit) state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // cmd_ready also looks at preset_n so it stays low during reset even though state is IDLE.
  always_comb begin
    cmd_ready   = 1'b0;
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
    rsp_valid   = 1'b0;
    unique case (state_q)
      StIdle:   cmd_ready = preset_n;
      StSetup:  apb.psel = 1'b1;
      StAccess: begin
        apb.psel    = 1'b1;
        apb.penable = 1'b1;
      end
      StResp:   rsp_valid = 1'b1;
      default:  cmd_ready = 1'b0;
    endcase
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
    end else if (accept) begin
      paddr_q  <= cmd_addr;
      pwrite_q <= cmd_write;
      pwdata_q <= cmd_wdata;
    end
  end

  // Completion takes precedence over a timeout expiring in the same cycle.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_latency_q <= '0;
    end else if ((state_q == StAccess) && apb.pready) begin
      rsp_rdata_q   <= pwrite_q ? '0 : apb.prdata;
      rsp_err_q     <= apb.pslverr;
      rsp_timeout_q <= 1'b0;
      rsp_latency_q <= lat_cnt;
    end else if (timeout_hit) begin
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b1;
      rsp_timeout_q <= 1'b1;
      rsp_latency_q <= lat_cnt;
    end
  end

  assign apb.paddr   = paddr_q;
  assign apb.pwrite  = pwrite_q;
  assign apb.pwdata  = pwdata_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign rsp_latency = rsp_latency_q;

`ifdef APB_REQ_STATS_EN
  logic                 resp_fire;
  logic [LAT_WIDTH-1:0] max_lat_q;

  assign resp_fire = (state_q == StResp);

  sat_counter #(.WIDTH(32)) u_stat_txn (
    .clk_i   (pclk),
    .rst_ni  (preset_n),
    .clear_i (stat_clear),
    .inc_i   (resp_fire),
    .count_o (stat_txn_count)
  );

  sat_counter #(.WIDTH(32)) u_stat_timeout (
    .clk_i   (pclk),
    .rst_ni  (preset_n),
    .clear_i (stat_clear),
    .inc_i   (resp_fire && rsp_timeout_q),
    .count_o (stat_timeout_count)
  );

  sat_counter #(.WIDTH(32)) u_stat_err (
    .clk_i   (pclk),
    .rst_ni  (preset_n),
    .clear_i (stat_clear),
    .inc_i   (resp_fire && rsp_err_q),
    .count_o (stat_err_count)
  );

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      max_lat_q <= '0;
    end else if (stat_clear) begin
      max_lat_q <= '0;
    end else if (resp_fire && (rsp_latency_q > max_lat_q)) begin
      max_lat_q <= rsp_latency_q;
    end
  end

  assign stat_max_latency = max_lat_q;
`endif
endmodule

// File: tb/tb_apb_txn_requester.sv
// Directed self-checking bench for apb_txn_requester (TIMEOUT_CYCLES = 8).
// Statistics checks are compiled in when APB_REQ_STATS_EN is defined.
module tb_apb_txn_requester;
  logic        pclk;
  logic        preset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_write;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [15:0] rsp_latency;
`ifdef APB_REQ_STATS_EN
  logic        stat_clear;
  logic [31:0] stat_txn_count;
  logic [31:0] stat_timeout_count;
  logic [31:0] stat_err_count;
  logic [15:0] stat_max_latency;
`endif

  int errors = 0;
  int checks = 0;

  apb_txn_requester_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) apb ();

  apb_txn_requester #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .LAT_WIDTH      (16),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .pclk               (pclk),
    .preset_n           (preset_n),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .cmd_addr           (cmd_addr),
    .cmd_write          (cmd_write),
    .cmd_wdata          (cmd_wdata),
    .rsp_valid          (rsp_valid),
    .rsp_rdata          (rsp_rdata),
    .rsp_err            (rsp_err),
    .rsp_timeout        (rsp_timeout),
    .rsp_latency        (rsp_latency),
`ifdef APB_REQ_STATS_EN
    .stat_clear         (stat_clear),
    .stat_txn_count     (stat_txn_count),
    .stat_timeout_count (stat_timeout_count),
    .stat_err_count     (stat_err_count),
    .stat_max_latency   (stat_max_latency),
`endif
    .apb                (apb.master)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Issues one command and plays the completer: pready rises in ACCESS cycle ready_at
  // (0 = never). Runs a fixed 40-cycle window so it always ends back in IDLE.
  task automatic run_txn(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                         input int ready_at, input logic [31:0] rd, input logic slverr,
                         output int psel_cyc, output int acc_cyc, output int valid_cyc,
                         output logic stable);
    psel_cyc = 0; acc_cyc = 0; valid_cyc = 0; stable = 1'b1;
    @(negedge pclk);
    cmd_valid = 1'b1; cmd_addr = addr; cmd_write = wr; cmd_wdata = wd;
    @(negedge pclk);
    cmd_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (apb.psel) begin
        psel_cyc++;
        if (apb.paddr !== addr || apb.pwrite !== wr || apb.pwdata !== wd) stable = 1'b0;
      end
      if (apb.psel && apb.penable) acc_cyc++;
      if (rsp_valid) valid_cyc++;
      apb.pready  = apb.psel && apb.penable && (acc_cyc == ready_at);
      apb.prdata  = rd;
      apb.pslverr = slverr;
      @(negedge pclk);
    end
    apb.pready = 1'b0; apb.pslverr = 1'b0;
  endtask

  task automatic test_reset();
    preset_n = 1'b0;
    repeat (2) @(negedge pclk);
    checks++; if (apb.psel !== 1'b0) begin errors++;
      $display("FAIL reset_psel: got %b want 0", apb.psel); end
    checks++; if (apb.penable !== 1'b0) begin errors++;
      $display("FAIL reset_penable: got %b want 0", apb.penable); end
    checks++; if (cmd_ready !== 1'b0) begin errors++;
      $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++;
      $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if ({rsp_rdata, rsp_err, rsp_timeout, rsp_latency} !== 50'd0) begin errors++;
      $display("FAIL reset_rsp_data: got %h/%b/%b/%0d want 0", rsp_rdata, rsp_err,
               rsp_timeout, rsp_latency); end
    checks++; if (apb.paddr !== 32'd0 || apb.pwdata !== 32'd0) begin errors++;
      $display("FAIL reset_apb_data: got %h/%h want 0", apb.paddr, apb.pwdata); end
    preset_n = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++;
      $display("FAIL reset_release_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_zero_wait_read();
    int p, a, v; logic s;
    run_txn(32'h10, 1'b0, 32'h0, 1, 32'hDEADBEEF, 1'b0, p, a, v, s);
    checks++; if (v !== 1) begin errors++;
      $display("FAIL zw_valid_cycles: got %0d want 1", v); end
    checks++; if (rsp_rdata !== 32'hDEADBEEF) begin errors++;
      $display("FAIL zw_rdata: got %h want deadbeef", rsp_rdata); end
    checks++; if (rsp_latency !== 16'd2) begin errors++;
      $display("FAIL zw_latency: got %0d want 2", rsp_latency); end
    checks++; if (rsp_err !== 1'b0 || rsp_timeout !== 1'b0) begin errors++;
      $display("FAIL zw_err_to: got %b/%b want 0/0", rsp_err, rsp_timeout); end
    checks++; if (p !== 2) begin errors++;
      $display("FAIL zw_psel_cycles: got %0d want 2", p); end
  endtask

  task automatic test_wait_write();
    int p, a, v; logic s;
    run_txn(32'h20, 1'b1, 32'h12345678, 5, 32'hFFFF0000, 1'b0, p, a, v, s);
    checks++; if (s !== 1'b1) begin errors++;
      $display("FAIL ww_stable: got %b want 1", s); end
    checks++; if (rsp_latency !== 16'd6) begin errors++;
      $display("FAIL ww_latency: got %0d want 6", rsp_latency); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++;
      $display("FAIL ww_rdata: got %h want 0", rsp_rdata); end
    checks++; if (a !== 5 || v !== 1) begin errors++;
      $display("FAIL ww_cycles: got access=%0d valid=%0d want 5/1", a, v); end
  endtask

  task automatic test_timeout();
    int p, a, v; logic s;
    run_txn(32'h24, 1'b0, 32'h0, 0, 32'h55AA55AA, 1'b0, p, a, v, s);
    checks++; if (a !== 8 || p !== 9) begin errors++;
      $display("FAIL to_cycles: got access=%0d psel=%0d want 8/9", a, p); end
    checks++; if (rsp_timeout !== 1'b1 || rsp_err !== 1'b1) begin errors++;
      $display("FAIL to_flags: got to=%b err=%b want 1/1", rsp_timeout, rsp_err); end
    checks++; if (rsp_latency !== 16'd9) begin errors++;
      $display("FAIL to_latency: got %0d want 9", rsp_latency); end
    checks++; if (rsp_rdata !== 32'h0 || v !== 1) begin errors++;
      $display("FAIL to_rdata_valid: got %h/%0d want 0/1", rsp_rdata, v); end
  endtask

  task automatic test_simultaneous();
    int p, a, v; logic s;
    run_txn(32'h28, 1'b0, 32'h0, 8, 32'hCAFEF00D, 1'b0, p, a, v, s);
    checks++; if (rsp_timeout !== 1'b0 || rsp_err !== 1'b0) begin errors++;
      $display("FAIL sim_flags: got to=%b err=%b want 0/0", rsp_timeout, rsp_err); end
    checks++; if (rsp_latency !== 16'd9) begin errors++;
      $display("FAIL sim_latency: got %0d want 9", rsp_latency); end
    checks++; if (rsp_rdata !== 32'hCAFEF00D) begin errors++;
      $display("FAIL sim_rdata: got %h want cafef00d", rsp_rdata); end
  endtask

  task automatic test_slverr();
    int p, a, v; logic s;
    run_txn(32'h2C, 1'b0, 32'h0, 2, 32'h01020304, 1'b1, p, a, v, s);
    checks++; if (rsp_err !== 1'b1 || rsp_timeout !== 1'b0) begin errors++;
      $display("FAIL se_flags: got err=%b to=%b want 1/0", rsp_err, rsp_timeout); end
    checks++; if (rsp_latency !== 16'd3 || rsp_rdata !== 32'h01020304) begin errors++;
      $display("FAIL se_lat_data: got %0d/%h want 3/01020304", rsp_latency, rsp_rdata); end
  endtask

  task automatic test_back_to_back();
    int first, second, ready_cnt, valid_cnt;
    first = -1; second = -1; ready_cnt = 0; valid_cnt = 0;
    @(negedge pclk);
    cmd_valid = 1'b1; cmd_addr = 32'h40; cmd_write = 1'b0; cmd_wdata = 32'h0;
    apb.pready = 1'b1; apb.prdata = 32'h0BADF00D; apb.pslverr = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge pclk);
      if (apb.psel && !apb.penable) begin
        if (first < 0) first = c; else second = c;
      end
      if (cmd_ready) ready_cnt++;
      if (rsp_valid) valid_cnt++;
    end
    cmd_valid = 1'b0; apb.pready = 1'b0;
    repeat (4) @(negedge pclk);
    checks++; if (second - first !== 4) begin errors++;
      $display("FAIL b2b_period: got %0d want 4", second - first); end
    checks++; if (ready_cnt !== 2) begin errors++;
      $display("FAIL b2b_ready_cycles: got %0d want 2", ready_cnt); end
    checks++; if (valid_cnt !== 2) begin errors++;
      $display("FAIL b2b_valid_cycles: got %0d want 2", valid_cnt); end
    checks++; if (rsp_rdata !== 32'h0BADF00D) begin errors++;
      $display("FAIL b2b_rdata: got %h want 0badf00d", rsp_rdata); end
  endtask

  task automatic test_reset_mid_access();
    int valid_seen, ready_seen;
    valid_seen = 0; ready_seen = 0;
    @(negedge pclk);
    cmd_valid = 1'b1; cmd_addr = 32'h30; cmd_write = 1'b1; cmd_wdata = 32'hA5A5A5A5;
    apb.pready = 1'b0;
    @(negedge pclk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge pclk);
    checks++; if (apb.psel !== 1'b1 || apb.penable !== 1'b1) begin errors++;
      $display("FAIL rm_in_access: got %b/%b want 1/1", apb.psel, apb.penable); end
    #2 preset_n = 1'b0;
    #1;
    checks++; if (apb.psel !== 1'b0 || apb.penable !== 1'b0) begin errors++;
      $display("FAIL rm_async_psel: got %b/%b want 0/0", apb.psel, apb.penable); end
    repeat (3) begin
      @(negedge pclk);
      if (rsp_valid) valid_seen++;
      if (cmd_ready) ready_seen++;
    end
    preset_n = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++;
      $display("FAIL rm_ready_after: got %b want 1", cmd_ready); end
    repeat (4) begin
      @(negedge pclk);
      if (rsp_valid) valid_seen++;
    end
    checks++; if (valid_seen !== 0 || ready_seen !== 0) begin errors++;
      $display("FAIL rm_no_rsp: got valid=%0d ready=%0d want 0/0", valid_seen, ready_seen); end
    checks++; if (rsp_latency !== 16'd0 || apb.pwdata !== 32'h0) begin errors++;
      $display("FAIL rm_cleared: got %0d/%h want 0/0", rsp_latency, apb.pwdata); end
  endtask

`ifdef APB_REQ_STATS_EN
  task automatic test_stats();
    int p, a, v; logic s;
    @(negedge pclk); stat_clear = 1'b1;
    @(negedge pclk); stat_clear = 1'b0;
    for (int i = 0; i < 3; i++) begin
      run_txn(32'h100 + 32'(i * 4), 1'b0, 32'h0, 1, 32'h1111 * (i + 1), 1'b0, p, a, v, s);
    end
    run_txn(32'h200, 1'b0, 32'h0, 2, 32'h0, 1'b1, p, a, v, s);
    run_txn(32'h204, 1'b0, 32'h0, 0, 32'h0, 1'b0, p, a, v, s);
    checks++; if (stat_txn_count !== 32'd5) begin errors++;
      $display("FAIL st_txn: got %0d want 5", stat_txn_count); end
    checks++; if (stat_err_count !== 32'd2) begin errors++;
      $display("FAIL st_err: got %0d want 2", stat_err_count); end
    checks++; if (stat_timeout_count !== 32'd1) begin errors++;
      $display("FAIL st_timeout: got %0d want 1", stat_timeout_count); end
    checks++; if (stat_max_latency !== 16'd9) begin errors++;
      $display("FAIL st_max_lat: got %0d want 9", stat_max_latency); end
    @(negedge pclk); stat_clear = 1'b1;
    @(negedge pclk); stat_clear = 1'b0;
    checks++; if ({stat_txn_count, stat_err_count, stat_timeout_count, stat_max_latency}
                  !== 112'd0) begin errors++;
      $display("FAIL st_clear: got %0d/%0d/%0d/%0d want 0", stat_txn_count, stat_err_count,
               stat_timeout_count, stat_max_latency); end
  endtask
`endif

  initial begin
    preset_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0; cmd_wdata = '0;
    apb.prdata = '0; apb.pready = 1'b0; apb.pslverr = 1'b0;
`ifdef APB_REQ_STATS_EN
    stat_clear = 1'b0;
`endif
    test_reset();
    test_zero_wait_read();
    test_wait_write();
    test_timeout();
    test_simultaneous();
    test_slverr();
    test_back_to_back();
    test_reset_mid_access();
`ifdef APB_REQ_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
